// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter: parity modes,
// shifter state encoding and the parity-bit helper.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_t;

  // data_xor is the XOR-reduction of the data word (1 = odd number of ones)
  function automatic logic parity_bit(input logic data_xor, input int mode);
    return (mode == PARITY_ODD) ? ~data_xor : data_xor;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with registered full/empty flags; pointers carry one extra
// wrap bit so equal low bits can be told apart as full or empty.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] wdata,
  input  logic             push,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      wr_nxt;
  logic [AW:0]      rd_nxt;
  logic             do_push;
  logic             do_pop;

  // a full FIFO refuses writes even when a pop frees a slot on the same edge
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign wr_nxt = do_push ? wr_ptr + 1'b1 : wr_ptr;
  assign rd_nxt = do_pop  ? rd_ptr + 1'b1 : rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
      empty  <= (wr_nxt == rd_nxt);
      full   <= (wr_nxt[AW] != rd_nxt[AW]) &&
                (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && do_push) begin
      mem[wr_ptr[AW-1:0]] <= wdata;
    end
  end

  assign rdata = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: words enter a FIFO over valid/ready and are
// serialised with configurable divisor, width, parity and stop bits.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   ST_IDLE   | line high, waiting for the FIFO to hold a word
//   ST_START  | start bit (line low) for one bit time
//   ST_DATA   | data bits LSB first, one bit time each
//   ST_PARITY | parity bit for one bit time (only when parity is enabled)
//   ST_STOP   | line high for STOP_BITS bit times; chains straight to START
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] in__data,
  input  logic                 in__valid,
  output logic                 out__ready,
  output logic                 out__tx,
  output logic                 out__busy
);

  if (CLKS_PER_BIT < 2) begin : g_bad_clks
    $error("uart_tx_fifo: CLKS_PER_BIT must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_width
    $error("uart_tx_fifo: DATA_BITS must be in 5..9");
  end
  if (PARITY != PARITY_NONE && PARITY != PARITY_ODD && PARITY != PARITY_EVEN) begin : g_bad_parity
    $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of two and at least 2");
  end

  localparam int            BW        = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

  tx_state_t            state;
  logic [BW-1:0]        baud_cnt;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_q;
  logic                 tx_q;

  logic [DATA_BITS-1:0] fifo_rdata;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 pop;
  logic                 bit_end;

  uart_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .wdata (in__data),
    .push  (in__valid),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bit_end = (baud_cnt == BAUD_LAST);

  // head is taken either from idle or on the final stop cycle, so frames chain
  assign pop = !fifo_empty &&
               ((state == ST_IDLE) ||
                (state == ST_STOP && bit_end && bit_cnt == STOP_LAST));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      if (pop) begin
        shreg <= fifo_rdata;
        par_q <= parity_bit(^fifo_rdata, PARITY);
      end

      case (state)
        ST_IDLE: begin
          tx_q     <= 1'b1;
          baud_cnt <= '0;
          bit_cnt  <= '0;
          if (pop) begin
            state <= ST_START;
            tx_q  <= 1'b0;
          end
        end

        ST_START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            state    <= ST_DATA;
            tx_q     <= shreg[0];
            shreg    <= shreg >> 1;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        ST_DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
              if (PARITY != PARITY_NONE) begin
                state <= ST_PARITY;
                tx_q  <= par_q;
              end else begin
                state <= ST_STOP;
                tx_q  <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              tx_q    <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        ST_PARITY: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            state    <= ST_STOP;
            tx_q     <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        ST_STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_cnt == STOP_LAST) begin
              bit_cnt <= '0;
              if (pop) begin
                state <= ST_START;
                tx_q  <= 1'b0;
              end else begin
                state <= ST_IDLE;
                tx_q  <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        default: begin
          state <= ST_IDLE;
          tx_q  <= 1'b1;
        end
      endcase
    end
  end

  assign out__tx    = tx_q;
  assign out__ready = !fifo_full;
  assign out__busy  = (state != ST_IDLE) || !fifo_empty;

endmodule
